// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and helpers for the LCD writer.
// Optional continuous refresh: define LCD_WRITER_REFRESH_EN.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_PWR_WAIT,
      S_INIT,
      S_HOME1,
      S_LINE1,
      S_HOME2,
      S_LINE2,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      X_IDLE,
      X_SETUP,
      X_EN,
      X_HOLD
   } xfer_t;

   localparam logic [7:0] FUNC_SET = 8'h38;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] ENTRY    = 8'h06;
   localparam logic [7:0] LINE1    = 8'h80;
   localparam logic [7:0] LINE2    = 8'hC0;
   localparam int         LINE_LEN = 16;

   function automatic logic [7:0] printable(input logic [7:0] c);
      return (c < 8'h20 || c > 8'h7E) ? 8'h20 : c;
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] step);
      logic [7:0] c;
      unique case (step)
         2'd0:    c = FUNC_SET;
         2'd1:    c = DISP_ON;
         2'd2:    c = CLEAR;
         default: c = ENTRY;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single-byte HD44780 write engine: setup, enable strobe, settle wait.
// Optional continuous refresh (in top): define LCD_WRITER_REFRESH_EN.
module lcd_xfer
   import lcd_pkg::*;
#(
   parameter int T_EN  = 16,
   parameter int T_CMD = 2000,
   parameter int T_CLR = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic [7:0] data,
   input  logic       rs,
   input  logic       long_wait,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic       ack
);

   localparam logic [31:0] EN_LAST  = 32'(T_EN - 1);
   localparam logic [31:0] CMD_LAST = 32'(T_CMD - 1);
   localparam logic [31:0] CLR_LAST = 32'(T_CLR - 1);

   xfer_t       phase, phase_n;
   logic [31:0] cnt, cnt_n;
   logic [7:0]  data_q;
   logic        rs_q;
   logic        long_q;
   logic        first;

   // The idle cycle that sees req is setup cycle 1; the byte passes through.
   assign first = (phase == X_IDLE) && req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase  <= X_IDLE;
         cnt    <= '0;
         data_q <= '0;
         rs_q   <= 1'b0;
         long_q <= 1'b0;
      end else begin
         phase <= phase_n;
         cnt   <= cnt_n;
         if (first) begin
            data_q <= data;
            rs_q   <= rs;
            long_q <= long_wait;
         end
      end
   end

   always_comb begin
      phase_n = phase;
      cnt_n   = cnt;
      ack     = 1'b0;
      unique case (phase)
         X_IDLE: begin
            if (req) begin
               phase_n = X_SETUP;
               cnt_n   = '0;
            end
         end
         X_SETUP: phase_n = X_EN;
         X_EN: begin
            if (cnt == EN_LAST) begin
               phase_n = X_HOLD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         X_HOLD: begin
            if (cnt == (long_q ? CLR_LAST : CMD_LAST)) begin
               phase_n = X_IDLE;
               cnt_n   = '0;
               ack     = 1'b1;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         default: phase_n = X_IDLE;
      endcase
   end

   assign lcd_data = first ? data : data_q;
   assign lcd_rs   = first ? rs : rs_q;
   assign lcd_en   = (phase == X_EN);

endmodule

// File: rtl/lcd_writer.sv
// Screen sequencer: power-on wait, init, then two 16-char lines from a ROM.
// Define LCD_WRITER_REFRESH_EN to rewrite the screen continuously.
module lcd_writer
   import lcd_pkg::*;
#(
   parameter int T_PWR = 1000000,
   parameter int T_EN  = 16,
   parameter int T_CMD = 2000,
   parameter int T_CLR = 82000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [5:0]  rom_addr,
   input  logic [31:0] rom_data,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_en,
   output logic        lcd_on,
   output logic        lcd_blon,
   output logic        busy,
   output logic        done
);

   localparam logic [31:0] PWR_LAST = 32'(T_PWR - 1);
   localparam logic [5:0]  L1_LAST  = 6'(LINE_LEN - 1);
   localparam logic [5:0]  L2_LAST  = 6'(2 * LINE_LEN - 1);

   state_t      state, state_n;
   logic [31:0] pwr_cnt, pwr_n;
   logic [1:0]  step, step_n;
   logic [5:0]  idx, idx_n;
   logic        done_q;
   logic        req;
   logic        ack;
   logic        rs;
   logic [7:0]  cmd;
   logic        long_wait;
   logic        unused_hi;

   assign unused_hi = ^rom_data[31:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_PWR_WAIT;
         pwr_cnt <= '0;
         step    <= '0;
         idx     <= '0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         pwr_cnt <= pwr_n;
         step    <= step_n;
         idx     <= idx_n;
         done_q  <= (state_n == S_DONE) && (state != S_DONE);
      end
   end

   always_comb begin
      state_n = state;
      pwr_n   = pwr_cnt;
      step_n  = step;
      idx_n   = idx;
      req     = 1'b0;
      rs      = 1'b0;
      cmd     = 8'h00;
      unique case (state)
         S_PWR_WAIT: begin
            if (pwr_cnt == PWR_LAST) begin
               state_n = S_INIT;
               pwr_n   = '0;
               step_n  = '0;
            end else begin
               pwr_n = pwr_cnt + 32'd1;
            end
         end
         S_INIT: begin
            req = 1'b1;
            cmd = init_cmd(step);
            if (ack) begin
               if (step == 2'd3) begin
                  state_n = S_HOME1;
                  idx_n   = '0;
               end else begin
                  step_n = step + 2'd1;
               end
            end
         end
         S_HOME1: begin
            req = 1'b1;
            cmd = LINE1;
            if (ack) state_n = S_LINE1;
         end
         S_LINE1: begin
            req = 1'b1;
            rs  = 1'b1;
            cmd = printable(rom_data[7:0]);
            if (ack) begin
               idx_n = idx + 6'd1;
               if (idx == L1_LAST) state_n = S_HOME2;
            end
         end
         S_HOME2: begin
            req = 1'b1;
            cmd = LINE2;
            if (ack) state_n = S_LINE2;
         end
         S_LINE2: begin
            req = 1'b1;
            rs  = 1'b1;
            cmd = printable(rom_data[7:0]);
            if (ack) begin
               if (idx == L2_LAST) state_n = S_DONE;
               else                idx_n   = idx + 6'd1;
            end
         end
         S_DONE: begin
`ifdef LCD_WRITER_REFRESH_EN
            state_n = S_HOME1;
            idx_n   = '0;
`else
            if (start) begin
               state_n = S_HOME1;
               idx_n   = '0;
            end
`endif
         end
         default: state_n = S_PWR_WAIT;
      endcase
   end

   assign long_wait = (state == S_INIT) && (cmd == CLEAR);

   lcd_xfer #(
      .T_EN (T_EN),
      .T_CMD(T_CMD),
      .T_CLR(T_CLR)
   ) u_xfer (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .data     (cmd),
      .rs       (rs),
      .long_wait(long_wait),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_en   (lcd_en),
      .ack      (ack)
   );

   assign rom_addr = idx;
   assign done     = done_q;
   assign lcd_rw   = 1'b0;
   assign lcd_on   = rst_n;
   assign lcd_blon = rst_n;

`ifdef LCD_WRITER_REFRESH_EN
   assign busy = 1'b1;
`else
   assign busy = (state != S_DONE);
`endif

endmodule
